// File: rtl/mem_access.sv
// Memory stage: turns execute results into data-bus requests and shapes load write-back data; optional trap macro MEM_MISALIGN_TRAP_EN.
// Latency 1 cycle for non-memory ops, 1 + bus cycles for loads/stores; in_ready drops for the whole bus transfer.
module mem_access #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_load,
  input  logic            in_store,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_we,
  input  logic [XLEN-1:0] in_pc,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [1:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_data_ok,
  input  logic [XLEN-1:0] dresp_data,
  output logic            out_valid,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic [XLEN-1:0] out_data,
  output logic [XLEN-1:0] out_pc,
  output logic            out_trap,
  output logic            fwd_we,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          r_state, w_next;
  logic            w_accept_mem, w_accept_alu, w_done, w_trap;
  logic [2:0]      w_lowmask;
  logic            w_misalign;
  logic [XLEN-1:0] w_addr_use;
  logic [XLEN-1:0] w_shifted, w_ld;
  logic [7:0]      w_bmask;

  logic [XLEN-1:0] r_addr, r_wdata, r_pc;
  logic [1:0]      r_size;
  logic            r_unsigned, r_load, r_rd_we;
  logic [4:0]      r_rd;
  logic            r_out_valid, r_out_we, r_out_trap;
  logic [4:0]      r_out_rd;
  logic [XLEN-1:0] r_out_data, r_out_pc;

  always_comb begin
    w_lowmask = 3'b000;
    case (in_size)
      2'd1:    w_lowmask = 3'b001;
      2'd2:    w_lowmask = 3'b011;
      2'd3:    w_lowmask = 3'b111;
      default: w_lowmask = 3'b000;
    endcase
  end

  assign w_misalign = |(in_addr[2:0] & w_lowmask);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_addr_use = in_addr;
`else
  // Without the trap, misaligned bits are silently dropped so the access stays naturally aligned.
  assign w_addr_use = {in_addr[XLEN-1:3], in_addr[2:0] & ~w_lowmask};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    in_ready     = 1'b0;
    dreq_valid   = 1'b0;
    w_accept_mem = 1'b0;
    w_accept_alu = 1'b0;
    w_done       = 1'b0;
    w_trap       = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!(in_load || in_store)) begin
            w_accept_alu = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
          end else if (w_misalign) begin
            w_trap = 1'b1;
`endif
          end else begin
            w_accept_mem = 1'b1;
            w_next       = BUSY;
          end
        end
      end
      BUSY: begin
        dreq_valid = 1'b1;
        if (dresp_data_ok) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_bmask = 8'h01;
    case (r_size)
      2'd1:    w_bmask = 8'h03;
      2'd2:    w_bmask = 8'h0F;
      2'd3:    w_bmask = 8'hFF;
      default: w_bmask = 8'h01;
    endcase
  end

  assign dreq_addr   = {r_addr[XLEN-1:3], 3'b000};
  assign dreq_size   = r_size;
  assign dreq_data   = r_wdata << {r_addr[2:0], 3'b000};
  assign dreq_strobe = (r_state == BUSY && !r_load) ? 8'(w_bmask << r_addr[2:0]) : 8'h00;
  assign w_shifted   = dresp_data >> {r_addr[2:0], 3'b000};

  always_comb begin
    w_ld = w_shifted;
    case (r_size)
      2'd0: w_ld = {{(XLEN-8){~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      2'd1: w_ld = {{(XLEN-16){~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      2'd2: w_ld = {{(XLEN-32){~r_unsigned & w_shifted[31]}}, w_shifted[31:0]};
      default: w_ld = w_shifted;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_pc        <= '0;
      r_size      <= '0;
      r_unsigned  <= 1'b0;
      r_load      <= 1'b0;
      r_rd_we     <= 1'b0;
      r_rd        <= '0;
      r_out_valid <= 1'b0;
      r_out_we    <= 1'b0;
      r_out_trap  <= 1'b0;
      r_out_rd    <= '0;
      r_out_data  <= '0;
      r_out_pc    <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_we    <= 1'b0;
      r_out_trap  <= 1'b0;
      if (w_accept_mem) begin
        r_addr     <= w_addr_use;
        r_wdata    <= in_wdata;
        r_pc       <= in_pc;
        r_size     <= in_size;
        r_unsigned <= in_unsigned;
        r_load     <= in_load;
        r_rd_we    <= in_rd_we;
        r_rd       <= in_rd;
      end
      if (w_accept_alu || w_trap) begin
        r_out_valid <= 1'b1;
        r_out_we    <= w_accept_alu & in_rd_we & (|in_rd);
        r_out_trap  <= w_trap;
        r_out_rd    <= in_rd;
        r_out_data  <= in_addr;
        r_out_pc    <= in_pc;
      end
      if (w_done) begin
        r_out_valid <= 1'b1;
        r_out_we    <= r_load & r_rd_we & (|r_rd);
        r_out_rd    <= r_rd;
        r_out_data  <= r_load ? w_ld : r_addr;
        r_out_pc    <= r_pc;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_we    = r_out_we;
  assign out_rd    = r_out_rd;
  assign out_data  = r_out_data;
  assign out_pc    = r_out_pc;
  assign out_trap  = r_out_trap;
  assign fwd_we    = r_out_we & r_out_valid;
  assign fwd_rd    = r_out_rd;
  assign fwd_data  = r_out_data;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed corner cases plus randomized ops against a byte-level reference model.
module tb_mem_access;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_ready, in_load, in_store, in_unsigned, in_rd_we;
  logic [1:0]      in_size;
  logic [XLEN-1:0] in_addr, in_wdata, in_pc;
  logic [4:0]      in_rd;
  logic            dreq_valid;
  logic [XLEN-1:0] dreq_addr, dreq_data;
  logic [1:0]      dreq_size;
  logic [7:0]      dreq_strobe;
  logic            dresp_data_ok;
  logic [XLEN-1:0] dresp_data;
  logic            out_valid, out_we, out_trap, fwd_we;
  logic [4:0]      out_rd, fwd_rd;
  logic [XLEN-1:0] out_data, out_pc, fwd_data;

  int total = 0;
  int bad   = 0;

  mem_access #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_pc(in_pc),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_rd(out_rd), .out_we(out_we), .out_data(out_data),
    .out_pc(out_pc), .out_trap(out_trap),
    .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Load result from the raw bus word: pick the addressed bytes, then extend.
  function automatic logic [63:0] ref_load(logic [63:0] raw, logic [2:0] off, logic [1:0] size, logic uns);
    int nb;
    logic [63:0] v, m;
    nb = 1 << size;
    v  = raw >> (8 * off);
    if (nb == 8) return v;
    m = (64'd1 << (8 * nb)) - 64'd1;
    v = v & m;
    if (!uns && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  task automatic do_op(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                       input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                       input bit rdwe, input logic [63:0] pc, input int waits, input logic [63:0] raw);
    logic [63:0] ea;
    logic [7:0]  exp_strb;
    int          nb;
    bit          mem, trap, exp_we;
    nb   = 1 << sz;
    mem  = ld | st;
    trap = 1'b0;
    ea   = addr;
    if (mem && (addr % nb) != 0) begin
`ifdef MEM_MISALIGN_TRAP_EN
      trap = 1'b1;
`else
      ea = addr - (addr % nb);
`endif
    end
    @(negedge clk);
    check_eq("idle_ready", in_ready, 1);
    in_valid = 1'b1; in_load = ld; in_store = st; in_size = sz; in_unsigned = uns;
    in_addr = addr; in_wdata = wdata; in_rd = rd; in_rd_we = rdwe; in_pc = pc;
    @(negedge clk);
    in_valid = 1'b0;
    if (!mem || trap) begin
      exp_we = !trap && rdwe && (rd != 0);
      check_eq("alu_valid", out_valid, 1);
      check_eq("alu_trap", out_trap, trap);
      check_eq("alu_we", out_we, exp_we);
      check_eq("alu_fwd_we", fwd_we, exp_we);
      check_eq("alu_rd", out_rd, rd);
      check_eq("alu_pc", out_pc, pc);
      check_eq("alu_no_req", dreq_valid, 0);
      if (!trap) begin
        check_eq("alu_data", out_data, addr);
        check_eq("alu_fwd_data", fwd_data, addr);
      end
    end else begin
      exp_strb = ld ? 8'h00 : 8'(((16'd1 << nb) - 16'd1) << ea[2:0]);
      for (int i = 0; i <= waits; i++) begin
        check_eq("busy_req", dreq_valid, 1);
        check_eq("busy_ready", in_ready, 0);
        check_eq("busy_out_valid", out_valid, 0);
        check_eq("req_addr", dreq_addr, ea & ~64'h7);
        check_eq("req_size", dreq_size, sz);
        check_eq("req_strobe", dreq_strobe, exp_strb);
        if (st) check_eq("req_data", dreq_data, wdata << (8 * ea[2:0]));
        if (i == waits) begin
          in_valid = 1'b0; dresp_data_ok = 1'b1; dresp_data = raw;
        end else begin
          in_valid = 1'b1; in_load = 1'($urandom); in_store = 1'($urandom);
          in_size = 2'($urandom); in_addr = {$urandom, $urandom};
          in_wdata = {$urandom, $urandom}; dresp_data = {$urandom, $urandom};
        end
        @(negedge clk);
      end
      dresp_data_ok = 1'b0;
      in_valid = 1'b0;
      exp_we = ld && rdwe && (rd != 0);
      check_eq("mem_valid", out_valid, 1);
      check_eq("mem_we", out_we, exp_we);
      check_eq("mem_fwd_we", fwd_we, exp_we);
      check_eq("mem_rd", out_rd, rd);
      check_eq("mem_pc", out_pc, pc);
      check_eq("mem_trap", out_trap, 0);
      check_eq("mem_req_done", dreq_valid, 0);
      if (ld) begin
        check_eq("load_data", out_data, ref_load(raw, ea[2:0], sz, uns));
        check_eq("load_fwd_data", fwd_data, ref_load(raw, ea[2:0], sz, uns));
      end
    end
    @(negedge clk);
    check_eq("pulse_end", out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_size = 2'd0;
    in_unsigned = 1'b0; in_addr = '0; in_wdata = '0; in_rd = '0; in_rd_we = 1'b0; in_pc = '0;
    dresp_data_ok = 1'b0; dresp_data = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_dreq_valid", dreq_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_trap", out_trap, 0);
    check_eq("rst_fwd_we", fwd_we, 0);
    reset = 1'b0;

    do_op(0, 0, 2'd0, 0, 64'h1234, 64'h0, 5'd5, 1, 64'h100, 0, 64'h0);
    do_op(1, 0, 2'd0, 0, 64'h1003, 64'h0, 5'd7, 1, 64'h104, 3, 64'h0000_0000_8000_0000);
    do_op(0, 1, 2'd1, 0, 64'h2006, 64'hBEEF, 5'd3, 1, 64'h108, 1, 64'h0);
    do_op(1, 0, 2'd2, 1, 64'h4, 64'h0, 5'd9, 1, 64'h10C, 2, 64'hF000_0000_0000_0000);
    do_op(1, 0, 2'd2, 0, 64'h2, 64'h0, 5'd4, 1, 64'h110, 1, 64'h1122_3344_8566_7788);
    do_op(1, 0, 2'd3, 1, 64'h8, 64'h0, 5'd0, 1, 64'h114, 0, 64'hDEAD_BEEF_CAFE_F00D);
    do_op(0, 0, 2'd0, 0, 64'h55, 64'h0, 5'd0, 1, 64'h118, 0, 64'h0);

    // Bus response while idle must not produce a result.
    @(negedge clk);
    dresp_data_ok = 1'b1; dresp_data = 64'hFFFF;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    check_eq("idle_resp_ignored", out_valid, 0);
    check_eq("idle_resp_ready", in_ready, 1);

    // Reset in the middle of a bus transfer.
    @(negedge clk);
    in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_size = 2'd3; in_addr = 64'h40;
    in_rd = 5'd6; in_rd_we = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("pre_rst_busy", dreq_valid, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_dreq", dreq_valid, 0);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0; dresp_data_ok = 1'b1; dresp_data = 64'h1234_5678;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    check_eq("late_resp_out_valid", out_valid, 0);
    @(negedge clk);
    check_eq("late_resp_dreq", dreq_valid, 0);
    check_eq("late_resp_out_valid2", out_valid, 0);

    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      do_op(kind == 1, kind == 2, 2'($urandom), 1'($urandom), {$urandom, $urandom},
            {$urandom, $urandom}, 5'($urandom), 1'($urandom), {$urandom, $urandom},
            $urandom_range(0, 4), {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
